// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF challenge/response sequencer: per response bit, enable one
// oscillator pair, settle, count synchronized edges over a fixed window, compare.
module ro_puf_ctrl #(
  parameter int NUM_RO     = 16,
  parameter int IDX_W      = $clog2(NUM_RO),
  parameter int RESP_W     = 8,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 4,
  parameter int WIN_CYC    = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [RESP_W*2*IDX_W-1:0] challenge,
  input  logic                      ro_a,
  input  logic                      ro_b,
  output logic [NUM_RO-1:0]         ro_en,
  output logic [IDX_W-1:0]          ro_sel_a,
  output logic [IDX_W-1:0]          ro_sel_b,
  output logic                      busy,
  output logic                      done,
  output logic [RESP_W-1:0]         response,
  output logic [RESP_W-1:0]         tie
);
  localparam int BIT_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [NUM_RO-1:0] EN_ONE = NUM_RO'(1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [RESP_W*2*IDX_W-1:0] chal_reg;
  logic [BIT_W-1:0]          bit_reg;
  logic [TMR_W-1:0]          tmr_reg;
  logic [CNT_W-1:0]          cnt_a_reg, cnt_b_reg;
  logic [2:0]                sync_a_reg, sync_b_reg;
  logic [RESP_W-1:0]         resp_reg, tie_reg;
  logic [IDX_W-1:0]          pair_a [RESP_W];
  logic [IDX_W-1:0]          pair_b [RESP_W];
  logic [IDX_W-1:0]          idx_a, idx_b;
  logic                      rise_a, rise_b, settle_end, win_end, last_bit;

  for (genvar gi = 0; gi < RESP_W; gi++) begin : g_pair
    assign pair_a[gi] = chal_reg[(2*gi)*IDX_W +: IDX_W];
    assign pair_b[gi] = chal_reg[(2*gi+1)*IDX_W +: IDX_W];
  end

  assign idx_a      = pair_a[bit_reg];
  assign idx_b      = pair_b[bit_reg];
  // bits [1:0] form the synchronizer, bit [2] is the edge-detect history
  assign rise_a     = sync_a_reg[1] & ~sync_a_reg[2];
  assign rise_b     = sync_b_reg[1] & ~sync_b_reg[2];
  assign settle_end = (tmr_reg == TMR_W'(SETTLE_CYC - 1));
  assign win_end    = (tmr_reg == TMR_W'(WIN_CYC - 1));
  assign last_bit   = (bit_reg == BIT_W'(RESP_W - 1));
  assign response   = resp_reg;
  assign tie        = tie_reg;

  always_comb begin
    state_next = state_reg;
    ro_en      = '0;
    ro_sel_a   = '0;
    ro_sel_b   = '0;
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
    case (state_reg)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (settle_end) state_next = MEASURE;
      MEASURE: if (win_end) state_next = COMPARE;
      COMPARE: state_next = last_bit ? DONE : SETTLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && state_reg != IDLE) state_next = IDLE;
    if (state_reg == SETTLE || state_reg == MEASURE) begin
      ro_en    = (EN_ONE << idx_a) | (EN_ONE << idx_b);
      ro_sel_a = idx_a;
      ro_sel_b = idx_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      chal_reg   <= '0;
      bit_reg    <= '0;
      tmr_reg    <= '0;
      cnt_a_reg  <= '0;
      cnt_b_reg  <= '0;
      sync_a_reg <= '0;
      sync_b_reg <= '0;
      resp_reg   <= '0;
      tie_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      sync_a_reg <= {sync_a_reg[1:0], ro_a};
      sync_b_reg <= {sync_b_reg[1:0], ro_b};
      if (state_next != state_reg)
        tmr_reg <= '0;
      else if (state_reg == SETTLE || state_reg == MEASURE)
        tmr_reg <= tmr_reg + 1'b1;
      case (state_reg)
        IDLE: if (start) begin
          chal_reg <= challenge;
          bit_reg  <= '0;
          resp_reg <= '0;
          tie_reg  <= '0;
        end
        SETTLE: begin
          cnt_a_reg <= '0;
          cnt_b_reg <= '0;
        end
        MEASURE: begin
          if (rise_a && !(&cnt_a_reg)) cnt_a_reg <= cnt_a_reg + 1'b1;
          if (rise_b && !(&cnt_b_reg)) cnt_b_reg <= cnt_b_reg + 1'b1;
        end
        COMPARE: if (!abort) begin
          resp_reg[bit_reg] <= (cnt_a_reg > cnt_b_reg);
          tie_reg[bit_reg]  <= (cnt_a_reg == cnt_b_reg);
          if (!last_bit) bit_reg <= bit_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ro_puf_ctrl.md
# ro_puf_ctrl

Challenge/response sequencer for the ring-oscillator PUF array. For each response bit it decodes a pair of oscillator indices from a captured challenge and enables only those two oscillators. It lets them settle, counts edges from both over a fixed clock window, and compares the counts to produce one response bit. The block sits between the host/register interface and the bank of `ro` instances plus their external output mux and frequency divider.

## Interface
Parameters:
- NUM_RO, 16: number of oscillators; power of two, ≥ 2.
- IDX_W, $clog2(NUM_RO): width of one oscillator index.
- RESP_W, 8: response bits per challenge.
- CNT_W, 16: width of the edge counters.
- SETTLE_CYC, 4: enable-to-measure settle cycles, ≥ 1.
- WIN_CYC, 1024: measurement window in clk cycles, ≥ 1.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request; honoured only in IDLE.
- abort  in  1  cancels an evaluation in progress.
- challenge  in  RESP_W*2*IDX_W  sampled on the accepted start. Bit i uses idx_a = challenge[2i*IDX_W +: IDX_W] and idx_b = challenge[(2i+1)*IDX_W +: IDX_W].
- ro_a  in  1  divided output of oscillator ro_sel_a; asynchronous; toggle rate ≤ clk/4.
- ro_b  in  1  divided output of oscillator ro_sel_b; same constraints as ro_a.
- ro_en  out  NUM_RO  per-oscillator enable; drives each `ro` en input.
- ro_sel_a  out  IDX_W  external mux select for ro_a.
- ro_sel_b  out  IDX_W  external mux select for ro_b.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; response is complete.
- response  out  RESP_W  response bits; held until the next accepted start.
- tie  out  RESP_W  bit i set when bit i was indeterminate.

## Operation
- FSM states: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE, start=1: latch challenge, set bit index i=0, clear response and tie, go to SETTLE. In any other state start is ignored.
- SETTLE:
  - ro_en has bits idx_a and idx_b set, all others 0.
  - ro_sel_a = idx_a, ro_sel_b = idx_b.
  - Both counters are cleared.
  - The state lasts SETTLE_CYC cycles, then goes to MEASURE.
- MEASURE:
  - ro_a and ro_b each pass through a 2-flop synchronizer plus an edge-detect flop.
  - Each counter increments on a cycle with a synchronized rising edge, and only in MEASURE.
  - Counters saturate at 2^CNT_W−1; they never wrap.
  - The state lasts WIN_CYC cycles, then goes to COMPARE.
- COMPARE (1 cycle):
  - ro_en = 0.
  - response[i] = (cnt_a > cnt_b).
  - tie[i] = (cnt_a == cnt_b). This includes both counters saturated.
  - If i == RESP_W−1, go to DONE; otherwise i++ and go to SETTLE.
- idx_a == idx_b: only that single ro_en bit is set. The sequence runs normally; response[i] = 0 and tie[i] = 1.
- DONE (1 cycle): done=1, then go to IDLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, and ro_en = 0 from the next cycle.
  - No done pulse.
  - response and tie show the bits written so far; unwritten bits stay 0.
- abort and start together in IDLE: start wins. Abort is meaningless in IDLE.

## Timing
- Reset values (rst_n=0 at a clk edge):
  - State IDLE; i=0.
  - ro_en=0, ro_sel_a=0, ro_sel_b=0.
  - busy=0, done=0, response=0, tie=0.
  - Counters and synchronizers = 0.
- Reset mid-evaluation behaves the same as reset: all of the above, no done pulse.
- start accepted at edge k: busy=1 and ro_en valid from cycle k+1.
- Each bit takes SETTLE_CYC + WIN_CYC + 1 cycles. ro_en is low for exactly one cycle (COMPARE) between consecutive bits.
- done is high in cycle k+1+RESP_W*(SETTLE_CYC+WIN_CYC+1). busy falls in the cycle after done.
- response[i] is updated at the end of bit i's COMPARE cycle and is visible the cycle after.
- Edge-count latency: a rising edge on ro_a is counted 3 clk cycles later, if that cycle is in MEASURE. Edges landing in SETTLE or COMPARE are discarded.

## Test plan
- **Basic:** NUM_RO=16, RESP_W=2, WIN_CYC=64, SETTLE_CYC=4. Challenge gives pairs (3,5) and (7,2). Toggle ro_a every 4 clk and ro_b every 6 clk in both pairs. Required: ro_en = 0x0028 during bit 0 and 0x0084 during bit 1. done at k+1+2*69 = k+139. response=2'b11, tie=0.
- **Tie/identical index:** pair (4,4). Required: ro_en = 0x0010, response[0]=0, tie[0]=1. Separately, feed equal-rate toggles on distinct indices. Required: equal counts give tie=1 and response bit 0.
- **Saturation:** CNT_W=4, WIN_CYC=200, both inputs toggling at clk/4. Required: both counts stop at 15, tie=1. Then ro_a fast and ro_b at clk/40 (5 edges). Required: response=1.
- **Abort:** assert abort in the MEASURE of bit 1 (RESP_W=4). Required: IDLE next cycle, ro_en=0, busy=0, no done. response[0] holds its value and bits 1–3 are 0. A new start afterwards runs a full evaluation.
- **Start while busy / reset:** pulse start during SETTLE. Required: ignored; the original challenge completes with unchanged done timing. Then drive rst_n low during MEASURE. Required: all outputs 0 at the next edge, no done.
- **Window edges:** place ro_a edges so their synchronized detection falls in the last SETTLE cycle, the first MEASURE cycle, the last MEASURE cycle and COMPARE. Required: only the two MEASURE edges are counted (cnt_a=2).
